dili_intt_ctrl: RTL and testbench
=================================

# dili_intt_ctrl

Sequencer for the Dilithium inverse-NTT butterfly unit (`dili_intt_bu`). It walks a 256-coefficient polynomial through the 8 Gentleman–Sande layers and issues one butterfly per cycle. For each butterfly it drives the coefficient-RAM read addresses and the zeta-ROM index, then drives write-back addresses and the write enable once the read-plus-butterfly pipeline latency has elapsed. It sits between the top-level command FSM (start/done) and the coefficient RAM / zeta ROM / butterfly datapath.

## Interface
- `N`, 256: polynomial length; fixed for Dilithium.
- `LOGN`, 8: number of layers, log2(N).
- `ADDR_W`, 8: coefficient address width, log2(N).
- `PIPE_LAT`, 2: cycles from a read issue to its write-back (RAM read latency + butterfly register stage); must be ≥1.

Ports:
- `clk_i` in 1: clock; all logic is rising-edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: start request; sampled only in IDLE.
- `busy_o` out 1: high while a transform is in progress.
- `done_o` out 1: one-cycle pulse when the transform has completed.
- `rd_en_o` out 1: read strobe to the coefficient RAM (both ports).
- `rd_addr_even_o` out ADDR_W: even-operand read address.
- `rd_addr_odd_o` out ADDR_W: odd-operand read address.
- `zeta_idx_o` out 8: zeta-ROM index, valid with `rd_en_o`. The ROM holds pre-negated zetas.
- `wr_en_o` out 1: write strobe to the coefficient RAM (both ports).
- `wr_addr_even_o` out ADDR_W: even-result write address (butterfly `a_even_o`).
- `wr_addr_odd_o` out ADDR_W: odd-result write address (butterfly `a_odd_o`).
- `layer_o` out 3: current layer index, for debug/status.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: when `start_i`=1, go to RUN with layer L=0 and butterfly counter b=0. If `start_i`=0, stay in IDLE.
- RUN: `rd_en_o`=1 every cycle; b increments each cycle.
  - When b=127: clear b and go to DRAIN.
- DRAIN: hold for PIPE_LAT cycles so that every write of layer L lands before layer L+1 reads. This avoids read-after-write hazards across layers.
  - At the end of DRAIN: if L<7, increment L and return to RUN; otherwise go to DONE.
- DONE: `done_o`=1 for one cycle, then go to IDLE.
- Address generation, with len = 1<<L, g = b>>L, o = b & (len−1):
  - even = g·2·len + o
  - odd = even + len
  - zeta_idx = (256>>L) − 1 − g
  - All values are computed modulo 2^ADDR_W; no value exceeds 255.
- Write-back: `wr_en_o` and both `wr_addr_*_o` are the read strobe and read addresses delayed by exactly PIPE_LAT cycles through a shift register.
- `busy_o` is high in RUN, DRAIN, and the registered cycle leading into DONE; it is low in IDLE and during the `done_o` cycle.
- `start_i` outside IDLE is ignored. It is not queued.
- Reset mid-operation: the FSM returns to IDLE immediately and the write-delay pipeline is cleared. In-flight writes are dropped and `done_o` is not issued.
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE.

## Timing
- Cycle 0 is the cycle in which `start_i`=1 is sampled in IDLE.
- Layer L reads occur in cycles 1 + L·(128+PIPE_LAT) through 128 + L·(128+PIPE_LAT).
- Writes occur PIPE_LAT cycles after the matching read. The last write is at cycle 8·(128+PIPE_LAT).
- `done_o` pulses at cycle 8·(128+PIPE_LAT)+1; this is cycle 1041 for PIPE_LAT=2.
- Throughput: one butterfly per cycle in RUN, 1024 butterflies in total. `rd_en_o` and `wr_en_o` are never high together across a layer boundary.
- A new `start_i` is accepted in the cycle after `done_o`.

## Configuration
- Macro: `DILI_INTT_CTRL_ABORT_EN`.
- Defined: adds input port `abort_i` (1 bit).
  - `abort_i`=1 in RUN or DRAIN forces IDLE on the next edge.
  - The write-delay pipeline is flushed, so no further `wr_en_o` pulses occur.
  - No `done_o` is issued; `busy_o` falls on the next edge.
  - `abort_i` is ignored in IDLE and DONE.
- Undefined: the port does not exist and the transform always runs to completion.

## Test plan
- Full run, PIPE_LAT=2: pulse `start_i` -> exactly 1024 `rd_en_o` and 1024 `wr_en_o` cycles, `done_o` at cycle 1041, `busy_o` high for cycles 1–1040.
- Layer 0 first cycles -> (even,odd,zeta) = (0,1,255), then (2,3,254); the last butterfly is (254,255,128).
- Layer 7 -> first (0,128,1), last (127,255,1); `layer_o`=7 throughout. `wr_addr_*` equal the `rd_addr_*` values from 2 cycles earlier.
- `start_i` held high for the whole run -> a single transform, then a new start is accepted in the cycle after `done_o`; there is no restart mid-run.
- Assert `rst_i` at cycle 300 -> all outputs 0 asynchronously, no `wr_en_o` after reset, no `done_o`; a fresh start then completes in 1041 cycles.
- With `DILI_INTT_CTRL_ABORT_EN`: `abort_i` at cycle 500 -> `rd_en_o`=0 and `wr_en_o`=0 from cycle 501, `busy_o`=0 at cycle 501, `done_o` never asserted.

Source files
------------

// File: rtl/dili_intt_ctrl.sv
// rtl/dili_intt_ctrl.sv - inverse-NTT butterfly sequencer for Dilithium (GS layers, pipelined write-back)
// Optional abort input enabled by DILI_INTT_CTRL_ABORT_EN.
module dili_intt_ctrl #(
  parameter int N        = 256,
  parameter int LOGN     = 8,
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
`ifdef DILI_INTT_CTRL_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_even_o,
  output logic [ADDR_W-1:0] rd_addr_odd_o,
  output logic [7:0]        zeta_idx_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_even_o,
  output logic [ADDR_W-1:0] wr_addr_odd_o,
  output logic [2:0]        layer_o
);

  localparam int BW = ADDR_W - 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_n;
  logic [2:0]      layer, layer_n;
  logic [BW-1:0]   b, b_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic            flush;
  logic            abort;

  logic [ADDR_W-1:0] bb, g, len, o, even_n, odd_n;
  logic [ADDR_W:0]   zfull;

  logic [PIPE_LAT-1:0] pv;
  logic [ADDR_W-1:0]   pe [PIPE_LAT];
  logic [ADDR_W-1:0]   po [PIPE_LAT];

`ifdef DILI_INTT_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_n = state;
    layer_n = layer;
    b_n     = b;
    dcnt_n  = dcnt;
    flush   = 1'b0;
    case (state)
      IDLE: if (start_i) begin
        state_n = RUN;
        layer_n = 3'd0;
        b_n     = '0;
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          flush   = 1'b1;
        end else if (b == BW'(N/2 - 1)) begin
          state_n = DRAIN;
          b_n     = '0;
          dcnt_n  = '0;
        end else begin
          b_n = b + 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_n = IDLE;
          flush   = 1'b1;
        end else if (dcnt == DW'(PIPE_LAT - 1)) begin
          if (layer == 3'(LOGN - 1)) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            layer_n = layer + 3'd1;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Addresses are derived from the next-cycle counters so they register alongside rd_en_o.
  always_comb begin
    bb     = {1'b0, b_n};
    g      = bb >> layer_n;
    len    = ADDR_W'(1) << layer_n;
    o      = bb & (len - ADDR_W'(1));
    even_n = (g << ({1'b0, layer_n} + 4'd1)) + o;
    odd_n  = even_n + len;
    zfull  = ((ADDR_W + 1)'(N) >> layer_n) - (ADDR_W + 1)'(1) - {1'b0, g};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      layer          <= '0;
      b              <= '0;
      dcnt           <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      rd_en_o        <= 1'b0;
      rd_addr_even_o <= '0;
      rd_addr_odd_o  <= '0;
      zeta_idx_o     <= '0;
    end else begin
      state          <= state_n;
      layer          <= layer_n;
      b              <= b_n;
      dcnt           <= dcnt_n;
      busy_o         <= (state_n == RUN) || (state_n == DRAIN);
      done_o         <= (state_n == DONE);
      rd_en_o        <= (state_n == RUN);
      rd_addr_even_o <= (state_n == RUN) ? even_n : '0;
      rd_addr_odd_o  <= (state_n == RUN) ? odd_n : '0;
      zeta_idx_o     <= (state_n == RUN) ? zfull[7:0] : 8'd0;
    end
  end

  // Write-back is the read strobe/addresses delayed PIPE_LAT cycles; abort drops in-flight writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pe[i] <= '0;
        po[i] <= '0;
      end
    end else if (flush) begin
      pv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pe[i] <= '0;
        po[i] <= '0;
      end
    end else begin
      pv[0] <= rd_en_o;
      pe[0] <= rd_addr_even_o;
      po[0] <= rd_addr_odd_o;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        po[i] <= po[i-1];
      end
    end
  end

  assign wr_en_o        = pv[PIPE_LAT-1];
  assign wr_addr_even_o = pe[PIPE_LAT-1];
  assign wr_addr_odd_o  = po[PIPE_LAT-1];
  assign layer_o        = layer;

endmodule

// File: tb/tb_dili_intt_ctrl.sv
// tb/tb_dili_intt_ctrl.sv - directed self-checking bench for dili_intt_ctrl (PIPE_LAT=2)
module tb_dili_intt_ctrl;

  localparam int PL   = 2;
  localparam int CYC  = 128 + PL;
  localparam int LAST = 8 * CYC + 1;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_e, rd_o, zeta, wr_e, wr_o;
  logic [2:0] layer;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dili_intt_ctrl #(.N(256), .LOGN(8), .ADDR_W(8), .PIPE_LAT(PL)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
`ifdef DILI_INTT_CTRL_ABORT_EN
    .abort_i        (abort),
`endif
    .busy_o         (busy),
    .done_o         (done),
    .rd_en_o        (rd_en),
    .rd_addr_even_o (rd_e),
    .rd_addr_odd_o  (rd_o),
    .zeta_idx_o     (zeta),
    .wr_en_o        (wr_en),
    .wr_addr_even_o (wr_e),
    .wr_addr_odd_o  (wr_o),
    .layer_o        (layer)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Read schedule for step k (k=0 is the first read cycle), using div/mod address form.
  task automatic exp_rd(input int k, output bit en, output int ev, output int od,
                        output int zt, output int lay);
    int r, len;
    lay = k / CYC;
    r   = k % CYC;
    en  = (k >= 0) && (lay < 8) && (r < 128);
    len = 1 << (lay & 7);
    ev  = (r / len) * 2 * len + (r % len);
    od  = ev + len;
    zt  = (256 >> (lay & 7)) - 1 - r / len;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_rd_addr"}, {rd_e, rd_o, zeta}, 0);
    check({tag, "_wr_addr"}, {wr_e, wr_o}, 0);
    check({tag, "_layer"}, layer, 0);
  endtask

  // Caller is at a negedge (cycle 0); checks cycles 1..LAST.
  task automatic run_transform(input bit hold);
    bit en, wen;
    int ev, od, zt, lay, wev, wod, wzt, wlay, nrd, nwr;
    nrd = 0;
    nwr = 0;
    start = 1'b1;
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      exp_rd(c - 1, en, ev, od, zt, lay);
      exp_rd(c - 1 - PL, wen, wev, wod, wzt, wlay);
      if (rd_en) nrd++;
      if (wr_en) nwr++;
      check("rd_en", rd_en, en);
      check("wr_en", wr_en, wen);
      check("busy", busy, (c <= LAST - 1));
      check("done", done, (c == LAST));
      check("no_rw_overlap_drain", rd_en & wr_en & ((c - 1) % CYC < PL), 0);
      if (en) begin
        check("rd_even", rd_e, ev);
        check("rd_odd", rd_o, od);
        check("zeta", zeta, zt);
        check("layer", layer, lay);
      end
      if (wen) begin
        check("wr_even", wr_e, wev);
        check("wr_odd", wr_o, wod);
      end
      case (c)
        1:    check("l0_first", {rd_e, rd_o, zeta}, {8'd0, 8'd1, 8'd255});
        2:    check("l0_second", {rd_e, rd_o, zeta}, {8'd2, 8'd3, 8'd254});
        128:  check("l0_last", {rd_e, rd_o, zeta}, {8'd254, 8'd255, 8'd128});
        911:  check("l7_first", {rd_e, rd_o, zeta, 5'd0, layer}, {8'd0, 8'd128, 8'd1, 8'd7});
        1038: check("l7_last", {rd_e, rd_o, zeta, 5'd0, layer}, {8'd127, 8'd255, 8'd1, 8'd7});
        1040: check("last_write", {wr_en, wr_e, wr_o}, {1'b1, 8'd127, 8'd255});
        default: ;
      endcase
    end
    check("rd_count", nrd, 1024);
    check("wr_count", nwr, 1024);
    @(negedge clk);
    check("post_done_busy", busy, 0);
    check("post_done_rd_en", rd_en, 0);
    if (hold) begin
      @(negedge clk);
      check("restart_rd_en", rd_en, 1);
      check("restart_addr", {rd_e, rd_o, zeta}, {8'd0, 8'd1, 8'd255});
      check("restart_busy", busy, 1);
    end else begin
      check("post_done_done", done, 0);
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle_no_start");

    run_transform(1'b0);

    do_reset();
    run_transform(1'b1);

    // Reset in the middle of layer 2 (cycle 300).
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("after_rst_wr_en", wr_en, 0);
      check("after_rst_done", done, 0);
    end
    run_transform(1'b0);

`ifdef DILI_INTT_CTRL_ABORT_EN
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_rd_en", rd_en, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      check("abort_quiet", {done, wr_en, rd_en, busy}, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
